game_sequencer: RTL
===================

# game_sequencer

Parametrised top-level game flow controller. It sequences the menu, a configurable number of levels, timed inter-level pauses, a player-requested hold, and a win/lose end screen. It sits between the input/keycode logic and the per-level engines and the screen renderer. It drives each level engine's start/enable line and the screen select code. It consumes each level's done strobe and miss count.

## Interface

Parameters:
- NUM_LEVELS, default 4: number of levels played in order; 1..(2^SCREEN_W − 2).
- MAX_MISSES, default 3: a level fails when miss_count ≥ MAX_MISSES.
- MISS_W, default 3: width of miss_count.
- PAUSE_CYCLES, default 50000000: cycles spent in the inter-level pause; ≥ 1.
- SCREEN_W, default 3: width of the screen code.

Ports:
- Clk, input, 1: system clock; everything is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: level-sensitive. Leaves MENU. In END it returns to MENU.
- hold, input, 1: level-sensitive player pause request.
- level_done, input, 1: the active level engine has completed. Held or pulsed; sampled only in PLAY.
- miss_count, input, MISS_W: miss count of the active level engine.
- screen, output, SCREEN_W: renderer select code.
- level_start, output, NUM_LEVELS: one-hot enable for the level engines. Bit k enables level k.
- level_idx, output, LVL_W = max(1, $clog2(NUM_LEVELS)): index of the current or upcoming level.
- freeze, output, 1: high while in HOLD; level engines stop their timers.
- win, output, 1: high in END when all levels were completed.

## Operation

States: MENU, PLAY, PAUSE, HOLD, END. level_idx is held in a register.

Transitions are evaluated each cycle, first match wins:
- reset (any state): go to MENU; level_idx = 0; win_r = 0; pause counter = 0.
- MENU:
  - start: go to PLAY with level_idx = 0.
- PLAY:
  - level_done with level_idx = NUM_LEVELS−1: go to END with win_r = 1.
  - level_done otherwise: go to PAUSE; level_idx += 1; counter = 0.
  - miss_count ≥ MAX_MISSES: go to END with win_r = 0.
  - hold: go to HOLD.
- PAUSE:
  - counter == PAUSE_CYCLES−1: go to PLAY.
  - otherwise counter += 1.
  - hold, level_done and miss_count are ignored.
- HOLD:
  - !hold: go to PLAY.
  - level_done and miss_count are ignored.
- END:
  - start: go to MENU; level_idx = 0; win_r = 0.

Output decode (Moore, decoded from registered state; no input-to-output combinational path):
- MENU: screen = 0; level_start = 0; freeze = 0.
- PLAY: screen = level_idx+1; level_start = one-hot(level_idx); freeze = 0.
- HOLD: same screen and level_start as PLAY; freeze = 1.
- PAUSE: screen = level_idx+1 (the upcoming level's screen); level_start = 0, which resets the level engines; freeze = 0.
- END: screen = all ones; level_start = 0; freeze = 0.
- win = win_r only while in END, else 0.

Width rules:
- miss_count is compared unsigned.
- level_idx never exceeds NUM_LEVELS−1.
- The pause counter is $clog2(PAUSE_CYCLES+1) bits wide and never wraps.

## Timing

- Reset values of all outputs: screen = 0, level_start = 0, level_idx = 0, freeze = 0, win = 0.
- Every transition takes one cycle. Outputs reflect the new state in the cycle after the triggering input is sampled.
- PAUSE lasts exactly PAUSE_CYCLES cycles. With PAUSE_CYCLES = 1 it lasts a single cycle.
- level_start for the next level goes high PAUSE_CYCLES+1 cycles after the level_done sample.
- level_done and a failing miss_count in the same PLAY cycle: done wins, so the level is completed.
- level_done and hold in the same cycle: done wins.
- start held continuously from END:
  - END → MENU, then MENU → PLAY on the next cycle.
  - The bench must drop start to stay in MENU.
- A held level_done is ignored after leaving PLAY. The level engine must clear it once level_start falls.
- reset mid-PAUSE or mid-HOLD: MENU on the next cycle; the counter is cleared.

## Test plan

- Reset, then start for 1 cycle with NUM_LEVELS = 2, PAUSE_CYCLES = 3 → next cycle screen = 1, level_start = 2'b01, level_idx = 0.
- level_done pulse in level 0 → PAUSE for exactly 3 cycles with screen = 2 and level_start = 0; then level_start = 2'b10, screen = 2.
- level_done in the last level → END, screen = 3'b111, win = 1. Then start → MENU, screen = 0, win = 0.
- miss_count = 3 (MAX_MISSES = 3) in level 0 → END with win = 0. Repeat with miss_count = 3 and level_done in the same cycle → PAUSE.
- hold asserted for 5 cycles in PLAY → freeze = 1 and level_start unchanged for 5 cycles; level_done pulsed during HOLD is ignored; freeze = 0 one cycle after hold drops.
- reset asserted in the second cycle of PAUSE → next cycle screen = 0, level_idx = 0, level_start = 0. A subsequent start replays level 0 with a full pause after it.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller. Walks the player through the
// menu, NUM_LEVELS levels separated by timed pauses, an optional player hold,
// and a win/lose end screen. All outputs are decoded from registered state.
//
// state | meaning
// ------+---------------------------------------------------------------
// MENU  | title screen, waiting for start
// PLAY  | level level_idx running, its engine enabled
// PAUSE | inter-level gap; engines held in reset, counting PAUSE_CYCLES
// HOLD  | player pause; engine stays enabled but frozen
// END   | end screen, win shows whether every level was completed
module game_sequencer #(
  parameter int NUM_LEVELS   = 4,
  parameter int MAX_MISSES   = 3,
  parameter int MISS_W       = 3,
  parameter int PAUSE_CYCLES = 50000000,
  parameter int SCREEN_W     = 3,
  localparam int LVL_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  level_done,
  input  logic [MISS_W-1:0]     miss_count,
  output logic [SCREEN_W-1:0]   screen,
  output logic [NUM_LEVELS-1:0] level_start,
  output logic [LVL_W-1:0]      level_idx,
  output logic                  freeze,
  output logic                  win
);

  localparam logic [2:0] S_MENU  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  localparam int          CNT_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES + 1) : 1;
  localparam int unsigned MAX_U    = MAX_MISSES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [LVL_W-1:0] IDX_LAST = LVL_W'(NUM_LEVELS - 1);

  logic [2:0]       state_q, state_d;
  logic [LVL_W-1:0] idx_q, idx_d;
  logic             win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miss_fail;

  // Unsigned compare; widened so MAX_MISSES may exceed the miss_count range.
  assign miss_fail = 32'(miss_count) >= MAX_U;

  // Next-state logic; within PLAY, done outranks a miss failure and hold.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_MENU: begin
        if (start) begin
          state_d = S_PLAY;
          idx_d   = '0;
        end
      end
      S_PLAY: begin
        if (level_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_END;
            win_d   = 1'b1;
          end else begin
            state_d = S_PAUSE;
            idx_d   = idx_q + LVL_W'(1);
            cnt_d   = '0;
          end
        end else if (miss_fail) begin
          state_d = S_END;
          win_d   = 1'b0;
        end else if (hold) begin
          state_d = S_HOLD;
        end
      end
      S_PAUSE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_PLAY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (!hold) begin
          state_d = S_PLAY;
        end
      end
      S_END: begin
        if (start) begin
          state_d = S_MENU;
          idx_d   = '0;
          win_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_MENU;
        idx_d   = '0;
        win_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_MENU;
      idx_q   <= '0;
      win_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    screen      = '0;
    level_start = '0;
    freeze      = 1'b0;
    win         = 1'b0;
    case (state_q)
      S_PLAY: begin
        screen      = SCREEN_W'(idx_q) + SCREEN_W'(1);
        level_start = NUM_LEVELS'(1) << idx_q;
      end
      S_HOLD: begin
        screen      = SCREEN_W'(idx_q) + SCREEN_W'(1);
        level_start = NUM_LEVELS'(1) << idx_q;
        freeze      = 1'b1;
      end
      S_PAUSE: begin
        screen = SCREEN_W'(idx_q) + SCREEN_W'(1);
      end
      S_END: begin
        screen = '1;
        win    = win_q;
      end
      default: begin
        screen = '0;
      end
    endcase
  end

  assign level_idx = idx_q;

endmodule
